// File: rtl/gray_counter_if.sv
// Control/status bundle for gray_counter: load/count controls in, binary/Gray count and tc out.
// The counter drives through the slave modport; whoever controls the counter uses master.
interface gray_counter_if #(
  parameter int N = 8
);
  logic         en;
  logic         up_dn;
  logic         load;
  logic         load_sel;
  logic [N-1:0] load_val;
  logic [N-1:0] bin_out;
  logic [N-1:0] gray_out;
  logic         tc;

  modport master (
    output en, up_dn, load, load_sel, load_val,
    input  bin_out, gray_out, tc
  );

  modport slave (
    input  en, up_dn, load, load_sel, load_val,
    output bin_out, gray_out, tc
  );
endinterface

// File: rtl/gray_counter.sv
// N-bit up/down counter with registered binary and Gray outputs, binary/Gray parallel load and tc pulse.
// Define GRAY_CNT_SAT_EN to saturate at the end points instead of wrapping modulo 2^N.
module gray_counter #(
  parameter int          N         = 8,
  parameter int unsigned RESET_VAL = 0
) (
  input  logic         clk,
  input  logic         rst_n,
  gray_counter_if.slave bus
);

  localparam logic [N-1:0] RST_BIN  = RESET_VAL[N-1:0];
  localparam logic [N-1:0] RST_GRAY = RST_BIN ^ (RST_BIN >> 1);
  localparam logic [N-1:0] ONE      = {{(N-1){1'b0}}, 1'b1};
  localparam logic [N-1:0] MAX_VAL  = {N{1'b1}};
  localparam logic [N-1:0] MIN_VAL  = {N{1'b0}};

  logic [N-1:0] bin_q;
  logic [N-1:0] gray_q;
  logic         tc_q;

  logic [N-1:0] next_bin;
  logic         next_tc;
  logic         at_max;
  logic         at_min;

  // Prefix XOR from the MSB down: b[N-1] = g[N-1], b[i] = b[i+1] ^ g[i].
  function automatic logic [N-1:0] gray_to_bin(input logic [N-1:0] g);
    logic [N-1:0] b;
    b[N-1] = g[N-1];
    for (int i = N - 2; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

  assign at_max = (bin_q == MAX_VAL);
  assign at_min = (bin_q == MIN_VAL);

  always_comb begin
    // NOTE: every output of this block gets a default first, so no path leaves it unassigned and no latch is inferred.
    next_bin = bin_q;
    next_tc  = 1'b0;
    if (bus.load) begin
      next_bin = bus.load_sel ? gray_to_bin(bus.load_val) : bus.load_val;
    end else if (bus.en) begin
      if (bus.up_dn) begin
`ifdef GRAY_CNT_SAT_EN
        if (at_max) next_tc  = 1'b1;
        else        next_bin = bin_q + ONE;
`else
        next_bin = bin_q + ONE;
        next_tc  = at_max;
`endif
      end else begin
`ifdef GRAY_CNT_SAT_EN
        if (at_min) next_tc  = 1'b1;
        else        next_bin = bin_q - ONE;
`else
        next_bin = bin_q - ONE;
        next_tc  = at_min;
`endif
      end
    end
  end

  // Gray is derived from next_bin, not from bin_q, so both outputs move on the same edge.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (!rst_n) begin
      bin_q  <= RST_BIN;
      gray_q <= RST_GRAY;
      tc_q   <= 1'b0;
    end else begin
      bin_q  <= next_bin;
      gray_q <= next_bin ^ (next_bin >> 1);
      tc_q   <= next_tc;
    end
  end

  assign bus.bin_out  = bin_q;
  assign bus.gray_out = gray_q;
  assign bus.tc       = tc_q;

endmodule

// File: tb/tb_gray_counter.sv
// Self-checking bench for gray_counter (N=4): a per-cycle compare against an arithmetic model plus directed literal checks.
// Build with GRAY_CNT_SAT_EN defined to exercise the saturating variant.
module tb_gray_counter;
  localparam int N    = 4;
  localparam int MODV = 1 << N;
  localparam int MAXV = MODV - 1;

  logic clk;
  logic rst_n;
  int   total;
  int   bad;

  gray_counter_if #(.N(N)) bus ();

  gray_counter #(.N(N), .RESET_VAL(0)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h, wanted %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Model: count held as an integer, Gray-to-binary solved by searching for the code word.
  int m_bin;
  int m_tc;
  int m_counted;

  function automatic int gray_of(input int b);
    return b ^ (b >> 1);
  endfunction

  function automatic int bin_of_gray(input int g);
    for (int v = 0; v < MODV; v++) begin
      if (gray_of(v) == g) return v;
    end
    return 0;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_bin <= 0; m_tc <= 0; m_counted <= 0;
    end else if (bus.load) begin
      m_bin     <= bus.load_sel ? bin_of_gray(int'(bus.load_val)) : int'(bus.load_val);
      m_tc      <= 0;
      m_counted <= 0;
    end else if (bus.en) begin
      if ((bus.up_dn && m_bin == MAXV) || (!bus.up_dn && m_bin == 0)) begin
        m_tc <= 1;
`ifdef GRAY_CNT_SAT_EN
        m_counted <= 0;
`else
        m_bin     <= bus.up_dn ? 0 : MAXV;
        m_counted <= 1;
`endif
      end else begin
        m_bin     <= bus.up_dn ? m_bin + 1 : m_bin - 1;
        m_tc      <= 0;
        m_counted <= 1;
      end
    end else begin
      m_tc <= 0; m_counted <= 0;
    end
  end

  // Compare process: every falling edge, DUT against model, plus one-bit Gray change on counted steps.
  logic [N-1:0] prev_gray;
  bit           have_prev;
  initial have_prev = 1'b0;
  always @(negedge clk) begin
    check("model bin",  32'(bus.bin_out),  32'(m_bin));
    check("model gray", 32'(bus.gray_out), 32'(gray_of(m_bin)));
    check("model tc",   32'(bus.tc),       32'(m_tc));
    if (have_prev && m_counted != 0 && rst_n)
      check("gray one-bit step", 32'($countones(bus.gray_out ^ prev_gray)), 32'd1);
    prev_gray = bus.gray_out;
    have_prev = 1'b1;
  end

  // Drive one set of inputs at the falling edge, return just after the rising edge that uses them.
  task automatic cyc(input bit e, input bit u, input bit ld, input bit sel, input logic [N-1:0] val);
    @(negedge clk);
    bus.en = e; bus.up_dn = u; bus.load = ld; bus.load_sel = sel; bus.load_val = val;
    @(posedge clk);
    #1;
  endtask

  task automatic expect_out(input string name, input logic [N-1:0] b, input logic [N-1:0] g, input bit t);
    check({name, " bin"},  32'(bus.bin_out),  32'(b));
    check({name, " gray"}, 32'(bus.gray_out), 32'(g));
    check({name, " tc"},   32'(bus.tc),       32'(t));
  endtask

  logic [N-1:0] up_gray [16];

  initial begin
    total = 0; bad = 0;
    up_gray = '{4'b0001, 4'b0011, 4'b0010, 4'b0110, 4'b0111, 4'b0101, 4'b0100, 4'b1100,
                4'b1101, 4'b1111, 4'b1110, 4'b1010, 4'b1011, 4'b1001, 4'b1000, 4'b0000};
    bus.en = 0; bus.up_dn = 1; bus.load = 0; bus.load_sel = 0; bus.load_val = '0;
    rst_n = 0;
    #12;
    expect_out("reset", 4'b0000, 4'b0000, 1'b0);
    rst_n = 1;

    // 1: count to 5, then async reset between edges
    for (int i = 0; i < 5; i++) cyc(1, 1, 0, 0, '0);
    expect_out("count5", 4'b0101, 4'b0111, 1'b0);
    #2 rst_n = 0;
    #1 expect_out("async reset", 4'b0000, 4'b0000, 1'b0);
    rst_n = 1;

    // 2: up count 17 steps through the wrap
    for (int k = 0; k < 16; k++) begin
      cyc(1, 1, 0, 0, '0);
      check($sformatf("up gray step %0d", k + 1), 32'(bus.gray_out), 32'(up_gray[k]));
      check($sformatf("up tc step %0d", k + 1), 32'(bus.tc), (k == 15) ? 32'd1 : 32'd0);
    end
    cyc(1, 1, 0, 0, '0);
    expect_out("up step 17", 4'b0001, 4'b0001, 1'b0);

    // 3: down count from 0
    cyc(0, 0, 1, 0, 4'b0000);
    cyc(1, 0, 0, 0, '0);
    expect_out("down wrap", 4'b1111, 4'b1000, 1'b1);
    cyc(1, 0, 0, 0, '0);
    expect_out("down next", 4'b1110, 4'b1001, 1'b0);

    // 4: Gray load beats en, then one up step
    cyc(1, 1, 1, 1, 4'b1101);
    expect_out("gray load", 4'b1001, 4'b1101, 1'b0);
    cyc(1, 1, 0, 0, '0);
    expect_out("after gray load", 4'b1010, 4'b1111, 1'b0);

    // 5: binary load then hold
    cyc(0, 1, 1, 0, 4'b1111);
    expect_out("bin load", 4'b1111, 4'b1000, 1'b0);
    for (int i = 0; i < 3; i++) begin
      cyc(0, 1, 0, 0, '0);
      expect_out("hold", 4'b1111, 4'b1000, 1'b0);
    end
    // load at the wrap point with en up still gives tc=0
    cyc(1, 1, 1, 0, 4'b0000);
    expect_out("load at max", 4'b0000, 4'b0000, 1'b0);

    // 6: end-point behaviour and direction change
    cyc(0, 1, 1, 0, 4'b1110);
`ifdef GRAY_CNT_SAT_EN
    cyc(1, 1, 0, 0, '0); expect_out("sat up 1", 4'b1111, 4'b1000, 1'b0);
    cyc(1, 1, 0, 0, '0); expect_out("sat up 2", 4'b1111, 4'b1000, 1'b1);
    cyc(1, 1, 0, 0, '0); expect_out("sat up 3", 4'b1111, 4'b1000, 1'b1);
    cyc(1, 0, 0, 0, '0); expect_out("sat down", 4'b1110, 4'b1001, 1'b0);
    cyc(0, 0, 1, 0, 4'b0000);
    cyc(1, 0, 0, 0, '0); expect_out("sat low", 4'b0000, 4'b0000, 1'b1);
`else
    cyc(1, 1, 0, 0, '0); expect_out("wrap up 1", 4'b1111, 4'b1000, 1'b0);
    cyc(1, 1, 0, 0, '0); expect_out("wrap up 2", 4'b0000, 4'b0000, 1'b1);
    cyc(1, 0, 0, 0, '0); expect_out("dir change", 4'b1111, 4'b1000, 1'b1);
    cyc(1, 0, 0, 0, '0); expect_out("down again", 4'b1110, 4'b1001, 1'b0);
`endif

    @(negedge clk);
    #1;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
